// File: rtl/instr_fetch_unit.sv
// Instruction fetch unit: wait-state instruction-memory requester feeding an in-order buffer to decode.
// Define IFU_PREFETCH_EN for a 2-entry buffer (fetch continues through a 1-cycle decode stall).
module instr_fetch_unit #(
    parameter int unsigned ADDR_W   = 12,
    parameter int unsigned RESET_PC = 0
) (
    input  logic              clock,
    input  logic              reset_n,
    output logic              imem_req,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic              imem_ack,
    input  logic [31:0]       imem_rdata,
    input  logic              redirect,
    input  logic [ADDR_W-1:0] redirect_pc,
    input  logic              id_ready,
    output logic              id_valid,
    output logic [31:0]       id_instr,
    output logic [4:0]        id_opcode,
    output logic [ADDR_W-1:0] id_pc
);

`ifdef IFU_PREFETCH_EN
    localparam int unsigned DEPTH = 2;
`else
    localparam int unsigned DEPTH = 1;
`endif
    localparam int unsigned INSTR_W = 32;
    localparam int unsigned CNT_W   = 2;

    typedef struct packed {
        logic [INSTR_W-1:0] instr;
        logic [ADDR_W-1:0]  pc;
    } entry_t;

    entry_t             buf_q [DEPTH];
    entry_t             buf_d [DEPTH];
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [ADDR_W-1:0]  pc_q, pc_d;
    logic               pop;
    logic               push;
    logic [CNT_W-1:0]   wr_idx;

    assign id_valid  = (cnt_q != '0);
    assign id_instr  = buf_q[0].instr;
    assign id_pc     = buf_q[0].pc;
    assign id_opcode = id_instr[31:27];

    assign pop       = id_valid & id_ready;
    // A slot vacated by this cycle's transfer counts as free, giving one instruction per cycle.
    assign imem_req  = reset_n & ((cnt_q != CNT_W'(DEPTH)) | pop);
    assign imem_addr = pc_q;
    assign push      = imem_req & imem_ack & ~redirect;
    assign wr_idx    = cnt_q - CNT_W'(pop);

    // Buffer shift/append and fetch-PC update; redirect flushes and drops any same-cycle ack.
    always_comb begin
        buf_d = buf_q;
        cnt_d = cnt_q;
        pc_d  = pc_q;
        if (redirect) begin
            cnt_d = '0;
            pc_d  = redirect_pc;
        end else begin
            if (pop) begin
                for (int unsigned i = 0; i + 1 < DEPTH; i++) begin
                    buf_d[i] = buf_q[i + 1];
                end
            end
            if (push) begin
                for (int unsigned i = 0; i < DEPTH; i++) begin
                    if (wr_idx == CNT_W'(i)) begin
                        buf_d[i].instr = imem_rdata;
                        buf_d[i].pc    = pc_q;
                    end
                end
                pc_d = pc_q + ADDR_W'(1);
            end
            cnt_d = cnt_q - CNT_W'(pop) + CNT_W'(push);
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            cnt_q <= '0;
            pc_q  <= ADDR_W'(RESET_PC);
            for (int unsigned i = 0; i < DEPTH; i++) begin
                buf_q[i] <= '0;
            end
        end else begin
            cnt_q <= cnt_d;
            pc_q  <= pc_d;
            buf_q <= buf_d;
        end
    end

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Self-checking bench for instr_fetch_unit: wait-state memory model, queue-based reference
// model compared every cycle, and directed scenarios with hand-computed expectations.
module tb_instr_fetch_unit;

    localparam int unsigned ADDR_W   = 12;
    localparam int unsigned RESET_PC = 0;
`ifdef IFU_PREFETCH_EN
    localparam int DEPTH = 2;
`else
    localparam int DEPTH = 1;
`endif

    logic              clock;
    logic              reset_n;
    logic              imem_req;
    logic [ADDR_W-1:0] imem_addr;
    logic              imem_ack;
    logic [31:0]       imem_rdata;
    logic              redirect;
    logic [ADDR_W-1:0] redirect_pc;
    logic              id_ready;
    logic              id_valid;
    logic [31:0]       id_instr;
    logic [4:0]        id_opcode;
    logic [ADDR_W-1:0] id_pc;

    int   errors = 0;
    int   checks = 0;
    int   wait_cfg = 0;
    int   wait_cnt = 0;
    logic force_ack;
    logic mem_tag;

    instr_fetch_unit #(.ADDR_W(ADDR_W), .RESET_PC(RESET_PC)) dut (
        .clock       (clock),
        .reset_n     (reset_n),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_ack    (imem_ack),
        .imem_rdata  (imem_rdata),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .id_ready    (id_ready),
        .id_valid    (id_valid),
        .id_instr    (id_instr),
        .id_opcode   (id_opcode),
        .id_pc       (id_pc)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    // Memory contents: word address * 4; with mem_tag the low address bits also fill the opcode field.
    function automatic logic [31:0] mem_word(input logic [ADDR_W-1:0] a, input logic tag);
        logic [31:0] w;
        w = {18'b0, a, 2'b00};
        if (tag) w[31:27] = a[4:0];
        return w;
    endfunction

    // Wait-state memory: acks after wait_cfg cycles of a held request.
    always @(posedge clock or negedge reset_n) begin
        if (!reset_n)                 wait_cnt <= 0;
        else if (imem_req && imem_ack) wait_cnt <= 0;
        else if (imem_req)            wait_cnt <= wait_cnt + 1;
    end
    assign imem_ack   = (imem_req && (wait_cnt >= wait_cfg)) || force_ack;
    assign imem_rdata = imem_ack ? mem_word(imem_addr, mem_tag) : 32'hDEAD_BEEF;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, want 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference model: expected fetch address plus a queue of acked, not-yet-consumed words.
    typedef struct {
        logic [ADDR_W-1:0] pc;
        logic [31:0]       instr;
    } exp_t;
    exp_t              exp_q[$];
    logic [ADDR_W-1:0] m_fetch_pc;

    always @(negedge clock) begin : cmp
        logic exp_req;
        if (!reset_n) begin
            chk("rst_imem_req", 32'(imem_req), 32'd0);
            chk("rst_id_valid", 32'(id_valid), 32'd0);
            chk("rst_id_instr", id_instr, 32'd0);
            chk("rst_id_pc", 32'(id_pc), 32'd0);
            exp_q.delete();
            m_fetch_pc = ADDR_W'(RESET_PC);
        end else begin
            exp_req = (exp_q.size() < DEPTH) || (exp_q.size() > 0 && id_ready);
            chk("m_imem_req", 32'(imem_req), 32'(exp_req));
            if (imem_req) chk("m_imem_addr", 32'(imem_addr), 32'(m_fetch_pc));
            chk("m_id_valid", 32'(id_valid), 32'(exp_q.size() > 0));
            if (id_valid && exp_q.size() > 0) begin
                chk("m_id_pc", 32'(id_pc), 32'(exp_q[0].pc));
                chk("m_id_instr", id_instr, exp_q[0].instr);
                chk("m_id_opcode", 32'(id_opcode), 32'(exp_q[0].instr[31:27]));
            end
            if (redirect) begin
                exp_q.delete();
                m_fetch_pc = redirect_pc;
            end else begin
                if (id_valid && id_ready && exp_q.size() > 0) void'(exp_q.pop_front());
                if (imem_req && imem_ack) begin
                    exp_q.push_back('{pc: m_fetch_pc, instr: mem_word(m_fetch_pc, mem_tag)});
                    m_fetch_pc = m_fetch_pc + 12'd1;
                end
            end
        end
    end

    task automatic cyc();
        @(posedge clock);
        #2;
    endtask

    initial begin
        int                n;
        int                acks;
        logic [ADDR_W-1:0] a;
        logic [ADDR_W-1:0] last_a;
        logic [ADDR_W-1:0] h_pc;
        logic [31:0]       h_instr;

        reset_n     = 1'b0;
        redirect    = 1'b0;
        redirect_pc = '0;
        id_ready    = 1'b1;
        force_ack   = 1'b0;
        mem_tag     = 1'b0;
        repeat (3) cyc();
        #1;
        chk("reset_req", 32'(imem_req), 32'd0);
        chk("reset_valid", 32'(id_valid), 32'd0);

        // Zero-wait streaming from reset: addr 0,1,2,3 back to back, instr 0,4,8,12 from cycle 2.
        reset_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            #1;
            chk("t1_req", 32'(imem_req), 32'd1);
            chk("t1_addr", 32'(imem_addr), 32'(i));
            if (i > 0) begin
                chk("t1_valid", 32'(id_valid), 32'd1);
                chk("t1_instr", id_instr, 32'(4 * (i - 1)));
            end
            cyc();
        end
        #1;
        chk("t1_instr", id_instr, 32'd12);

        // Three wait cycles per fetch: each address is presented for 3 waits plus the ack cycle.
        cyc();
        wait_cfg = 3;
        mem_tag  = 1'b1;
        last_a   = '0;
        for (int f = 0; f < 3; f++) begin
            #1;
            a = imem_addr;
            if (f > 0) chk("t2_next_addr", 32'(a), 32'(last_a + 12'd1));
            n = 0;
            while (!imem_ack && n < 20) begin
                cyc();
                #1;
                n++;
            end
            chk("t2_hold_cycles", 32'(n + 1), 32'd4);
            chk("t2_addr_held", 32'(imem_addr), 32'(a));
            last_a = a;
            cyc();
        end

        // Redirect to 0x003, then redirect to 0x040 exactly while 0x005 is being acked.
        wait_cfg    = 0;
        redirect    = 1'b1;
        redirect_pc = 12'h003;
        cyc();
        redirect = 1'b0;
        #1;
        chk("t3a_valid", 32'(id_valid), 32'd0);
        chk("t3a_req", 32'(imem_req), 32'd1);
        chk("t3a_addr", 32'(imem_addr), 32'h003);
        n = 0;
        while (imem_addr != 12'h005 && n < 10) begin
            cyc();
            #1;
            n++;
        end
        chk("t3_reach_5", 32'(imem_addr), 32'h005);
        redirect    = 1'b1;
        redirect_pc = 12'h040;
        #1;
        chk("t3_ack_on_5", 32'(imem_ack), 32'd1);
        cyc();
        redirect = 1'b0;
        #1;
        chk("t3_valid_low", 32'(id_valid), 32'd0);
        chk("t3_req", 32'(imem_req), 32'd1);
        chk("t3_addr", 32'(imem_addr), 32'h040);
        cyc();
        #1;
        chk("t3_valid", 32'(id_valid), 32'd1);
        chk("t3_pc", 32'(id_pc), 32'h040);
        chk("t3_instr", id_instr, 32'h0000_0100);

        // Decode stall for 5 cycles: head held, buffer fills to its depth, order kept on release.
        cyc();
        id_ready = 1'b0;
        #1;
        h_pc    = id_pc;
        h_instr = id_instr;
        acks    = int'(imem_ack);
        chk("t4_head_pc", 32'(h_pc), 32'h041);
        chk("t4_head_instr", h_instr, 32'h0800_0104);
        for (int k = 1; k < 5; k++) begin
            cyc();
            #1;
            chk("t4_stable_pc", 32'(id_pc), 32'(h_pc));
            chk("t4_stable_instr", id_instr, h_instr);
            acks += int'(imem_ack);
        end
        chk("t4_req_off", 32'(imem_req), 32'd0);
        chk("t4_buffered", 32'(acks + 1), 32'(DEPTH));
        cyc();
        id_ready = 1'b1;
        #1;
        chk("t4_rel0", 32'(id_pc), 32'h041);
        cyc();
        #1;
        chk("t4_rel1", 32'(id_pc), 32'h042);
        cyc();
        #1;
        chk("t4_rel2", 32'(id_pc), 32'h043);

        // Address wrap 0xFFF -> 0x000.
        cyc();
        redirect    = 1'b1;
        redirect_pc = 12'hFFE;
        cyc();
        redirect = 1'b0;
        #1;
        chk("t5_addr_ffe", 32'(imem_addr), 32'hFFE);
        cyc();
        #1;
        chk("t5_addr_fff", 32'(imem_addr), 32'hFFF);
        cyc();
        #1;
        chk("t5_addr_wrap", 32'(imem_addr), 32'h000);
        chk("t5_pc_fff", 32'(id_pc), 32'hFFF);
        chk("t5_instr_fff", id_instr, 32'hF800_3FFC);
        chk("t5_opcode_fff", 32'(id_opcode), 32'h1F);
        cyc();
        #1;
        chk("t5_pc_wrap", 32'(id_pc), 32'h000);

        // Reset pulsed in the middle of a waited fetch, with a stray ack while in reset.
        cyc();
        wait_cfg = 3;
        cyc();
        cyc();
        #1;
        chk("t6_pre_req", 32'(imem_req), 32'd1);
        chk("t6_pre_noack", 32'(imem_ack), 32'd0);
        reset_n   = 1'b0;
        force_ack = 1'b1;
        #1;
        chk("t6_req_off", 32'(imem_req), 32'd0);
        chk("t6_valid_off", 32'(id_valid), 32'd0);
        chk("t6_instr_zero", id_instr, 32'd0);
        chk("t6_pc_zero", 32'(id_pc), 32'd0);
        repeat (2) cyc();
        force_ack = 1'b0;
        wait_cfg  = 0;
        reset_n   = 1'b1;
        #1;
        chk("t6_restart_req", 32'(imem_req), 32'd1);
        chk("t6_restart_addr", 32'(imem_addr), 32'(RESET_PC));
        cyc();
        #1;
        chk("t6_restart_valid", 32'(id_valid), 32'd1);
        chk("t6_restart_pc", 32'(id_pc), 32'(RESET_PC));

        repeat (3) cyc();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d checks=%0d", errors, checks);
        $fatal(1, "watchdog expired");
    end

endmodule
